l2_arbiter: RTL

- Two-requester arbiter that shares the single unified L2 cache port between the L1 I-cache and the L1 D-cache miss interfaces.
- Latches the winning request, drives the L2 with stable command/address/data until the L2 ready pulse, then routes the response back to the winner.
- Sits between both L1 caches and the L2; the L2 and main-memory side are unchanged.

---
 rtl/l2_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/l2_arbiter.sv
// Two-requester arbiter sharing the unified L2 port between the L1 I-cache and D-cache.
// Optional build macro L2ARB_DPRIO_EN: D-cache wins every tie instead of round-robin.
module l2_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  output logic              i_stall,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic [DATA_W-1:0] l2_rdata,
  input  logic              l2_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]        state;
  logic              grant;       // 1 = D-cache
  logic              last_grant;  // 1 = D-cache
  logic              op_q;        // 1 = write
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              req_i, req_d;
  logic              pick_d;
  logic              win_op;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              done;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;

  always_comb begin
    pick_d = req_d;
    if (req_i && req_d) begin
`ifdef L2ARB_DPRIO_EN
      pick_d = 1'b1;
`else
      pick_d = ~last_grant;
`endif
    end
  end

  // A requester asserting both read and write is served as a read.
  assign win_op    = pick_d ? (d_write & ~d_read) : (i_write & ~i_read);
  assign win_addr  = pick_d ? d_addr  : i_addr;
  assign win_wdata = pick_d ? d_wdata : i_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i || req_d) begin
            grant      <= pick_d;
            last_grant <= pick_d;
            op_q       <= win_op;
            addr_q     <= win_addr;
            wdata_q    <= win_wdata;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (l2_ready) state <= HOLD;
        end
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Command is dropped in the ready cycle so the L2 never re-samples it.
  assign done     = (state == BUSY) & l2_ready;
  assign l2_read  = (state == BUSY) & ~op_q & ~l2_ready;
  assign l2_write = (state == BUSY) &  op_q & ~l2_ready;
  assign l2_addr  = addr_q;
  assign l2_wdata = wdata_q;

  assign i_ready = done & ~grant;
  assign d_ready = done &  grant;
  assign i_rdata = (i_ready & ~op_q) ? l2_rdata : '0;
  assign d_rdata = (d_ready & ~op_q) ? l2_rdata : '0;

  // Stalls are forced low while reset is held.
  assign i_stall = reset & req_i & ~i_ready;
  assign d_stall = reset & req_d & ~d_ready;

endmodule
